move_input_conditioner: RTL and testbench

- Conditions the four raw direction buttons for the adventure-game room FSM, which sits directly downstream of this block.
- Each raw input is synchronized, then debounced.
- At most one single-cycle, one-hot move pulse (n/s/e/w) is issued per press, so the room FSM advances exactly one room per press.
- Also reports simultaneous-press conflicts and keeps a saturating count of accepted moves.

---
 rtl/move_input_conditioner.sv | 123 ++++++++++++
 tb/tb_move_input_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/move_input_conditioner.sv
// Direction-button conditioner: sync, debounce, one move pulse per press.
// Ports: clk, reset (sync, active-high), n/s/e/w_raw buttons, enable;
//        n/s/e/w move pulses, conflict pulse, busy, move_count.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             n_raw,
    input  logic             s_raw,
    input  logic             e_raw,
    input  logic             w_raw,
    input  logic             enable,
    output logic             n,
    output logic             s,
    output logic             e,
    output logic             w,
    output logic             conflict,
    output logic             busy,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic {
        IDLE,
        WAIT_RELEASE
    } state_t;

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere: {n, s, e, w}
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] db;
    logic [7:0] cnt [4];
    logic       single;

    state_t     state;
    state_t     state_d;
    logic [3:0] pulse_q;
    logic [3:0] pulse_d;
    logic       conflict_d;
    logic       count_en;

    assign raw = {n_raw, s_raw, e_raw, w_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level must differ from db for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (cnt[i] == LAST) begin
                        db[i]  <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // True when at most one bit set; combined with db != 0 below
    assign single = (db & (db - 4'd1)) == 4'd0;

    always_comb begin
        state_d    = state;
        pulse_d    = '0;
        conflict_d = 1'b0;
        count_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (db != 4'd0) begin
                    state_d = WAIT_RELEASE;
                    if (!single) begin
                        conflict_d = 1'b1;
                    end else if (enable) begin
                        pulse_d  = db;
                        count_en = 1'b1;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (db == 4'd0) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pulse_q    <= '0;
            conflict   <= 1'b0;
            move_count <= '0;
        end else begin
            state    <= state_d;
            pulse_q  <= pulse_d;
            conflict <= conflict_d;
            if (count_en && (move_count != '1))
                move_count <= move_count + CNT_W'(1);
        end
    end

    assign {n, s, e, w} = pulse_q;
    assign busy         = (state == WAIT_RELEASE);

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner: latency, glitch, conflict,
// stagger, enable gating, count saturation (CNT_W=2 copy), mid-press reset.
module tb_move_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst2 = 1'b1;
    logic n_raw = 1'b0;
    logic s_raw = 1'b0;
    logic e_raw = 1'b0;
    logic w_raw = 1'b0;
    logic enable = 1'b1;

    logic n, s, e, w, conflict, busy;
    logic [7:0] move_count;
    logic n2, s2, e2, w2, conflict2, busy2;
    logic [1:0] count2;

    int total = 0;
    int bad = 0;
    int t, pn, ps, pe, pw, pc, pe_at, pw_at, pc_at, fb, idle_t;
    logic prev_busy;
    logic prev_any;
    int exp2 [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    move_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .n_raw(n_raw), .s_raw(s_raw), .e_raw(e_raw), .w_raw(w_raw),
        .enable(enable),
        .n(n), .s(s), .e(e), .w(w),
        .conflict(conflict), .busy(busy), .move_count(move_count)
    );

    move_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst2),
        .n_raw(n_raw), .s_raw(s_raw), .e_raw(e_raw), .w_raw(w_raw),
        .enable(enable),
        .n(n2), .s(s2), .e(e2), .w(w2),
        .conflict(conflict2), .busy(busy2), .move_count(count2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        t = 0; pn = 0; ps = 0; pe = 0; pw = 0; pc = 0;
        pe_at = 0; pw_at = 0; pc_at = 0; fb = 0; idle_t = 0;
        prev_busy = busy;
    endtask

    task automatic step(input int k);
        logic any;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            t++;
            if (n) pn++;
            if (s) ps++;
            if (e) pe++;
            if (w) pw++;
            if (conflict) pc++;
            if (e && pe_at == 0) pe_at = t;
            if (w && pw_at == 0) pw_at = t;
            if (conflict && pc_at == 0) pc_at = t;
            if (busy && fb == 0) fb = t;
            if (!busy && prev_busy) idle_t = t;
            prev_busy = busy;
            any = n | s | e | w;
            chk("onehot", int'($countones({n, s, e, w}) <= 1), 1);
            chk("no_back_to_back", int'(any && prev_any), 0);
            prev_any = any;
        end
    endtask

    initial begin
        prev_any = 1'b0;
        clr();
        step(3);
        chk("rst_dirs", int'({n, s, e, w}), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(move_count), 0);
        chk("rst_count2", int'(count2), 0);
        reset = 1'b0;

        // glitch of 3 cycles
        clr();
        n_raw = 1'b1;
        step(3);
        n_raw = 1'b0;
        step(15);
        chk("gl_pulses", pn + ps + pe + pw, 0);
        chk("gl_conflict", pc, 0);
        chk("gl_count", int'(move_count), 0);
        chk("gl_busy", fb, 0);

        // single east press
        clr();
        e_raw = 1'b1;
        step(20);
        e_raw = 1'b0;
        step(15);
        chk("sp_e_pulses", pe, 1);
        chk("sp_e_latency", pe_at, 7);
        chk("sp_other", pn + ps + pw, 0);
        chk("sp_conflict", pc, 0);
        chk("sp_count", int'(move_count), 1);
        chk("sp_busy_rise", fb, 7);
        chk("sp_busy_fall", idle_t, 27);
        chk("sp_busy_end", int'(busy), 0);

        // simultaneous south+east
        clr();
        s_raw = 1'b1;
        e_raw = 1'b1;
        step(15);
        s_raw = 1'b0;
        e_raw = 1'b0;
        step(15);
        chk("sim_conflict", pc, 1);
        chk("sim_conflict_at", pc_at, 7);
        chk("sim_dirs", pn + ps + pe + pw, 0);
        chk("sim_count", int'(move_count), 1);
        chk("sim_busy_fall", idle_t, 22);

        // staggered west then north
        clr();
        w_raw = 1'b1;
        step(2);
        n_raw = 1'b1;
        step(13);
        w_raw = 1'b0;
        n_raw = 1'b0;
        step(15);
        chk("stg_w", pw, 1);
        chk("stg_w_at", pw_at, 7);
        chk("stg_n", pn, 0);
        chk("stg_conflict", pc, 0);
        chk("stg_count", int'(move_count), 2);
        chk("stg_busy_end", int'(busy), 0);

        // repeat west
        clr();
        w_raw = 1'b1;
        step(10);
        w_raw = 1'b0;
        step(15);
        chk("rep_w", pw, 1);
        chk("rep_w_at", pw_at, 7);
        chk("rep_count", int'(move_count), 3);

        // enable low
        clr();
        enable = 1'b0;
        s_raw = 1'b1;
        step(10);
        s_raw = 1'b0;
        step(15);
        enable = 1'b1;
        chk("en_s", ps, 0);
        chk("en_conflict", pc, 0);
        chk("en_busy_rise", fb, 7);
        chk("en_busy_fall", idle_t, 17);
        chk("en_count", int'(move_count), 3);

        // saturation on the 2-bit counter copy
        rst2 = 1'b1;
        step(2);
        rst2 = 1'b0;
        for (int p = 0; p < 5; p++) begin
            clr();
            e_raw = 1'b1;
            step(10);
            e_raw = 1'b0;
            step(15);
            chk("sat_e", pe, 1);
            chk("sat_count2", int'(count2), exp2[p]);
            chk("sat_count", int'(move_count), 4 + p);
        end

        // reset right after a pulse, button still held
        clr();
        e_raw = 1'b1;
        step(7);
        chk("mr_first_e", int'(e), 1);
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step(1);
            chk("mr_dirs", int'({n, s, e, w}), 0);
            chk("mr_conflict", int'(conflict), 0);
            chk("mr_busy", int'(busy), 0);
            chk("mr_count", int'(move_count), 0);
        end
        reset = 1'b0;
        clr();
        step(12);
        chk("mr_e_pulses", pe, 1);
        chk("mr_e_at", pe_at, 7);
        chk("mr_count_after", int'(move_count), 1);
        e_raw = 1'b0;
        step(15);
        chk("mr_busy_end", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
